// File: rtl/counter_cmd_seq_if.sv
// Command handshake bus feeding counter_cmd_seq: valid/ready plus opcode and argument.
// The master drives the command fields; the sequencer (slave) returns cmd_ready.
interface counter_cmd_seq_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/counter_cmd_seq.sv
// Command sequencer: FIFO-buffered LOAD/UP/DOWN/WAIT commands replayed as registered counter controls.
// Optional feature macro CMD_SEQ_FLUSH_EN adds flush_i (empty FIFO, abort command, force IDLE).
module counter_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    counter_cmd_seq_if.slave     cmd,
`ifdef CMD_SEQ_FLUSH_EN
    input  logic                 flush_i,
`endif
    output logic                 en_o,
    output logic                 dn_o,
    output logic                 load_o,
    output logic [WIDTH-1:0]     data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    typedef enum logic {IDLE, EXEC} state_t;

    logic [1:0]       op_mem_q  [DEPTH];
    logic [WIDTH-1:0] arg_mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             en_q, en_d, dn_q, dn_d, load_q, load_d, done_q, done_d, busy_q, busy_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             full, empty, push, pop, flush, last, zero_len;
    logic [1:0]       head_op;
    logic [WIDTH-1:0] head_arg;

`ifdef CMD_SEQ_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push     = cmd.cmd_valid && !full && !flush;
    assign head_op  = op_mem_q[rd_ptr_q[AW-1:0]];
    assign head_arg = arg_mem_q[rd_ptr_q[AW-1:0]];
    assign zero_len = (head_op != OP_LOAD) && (head_arg == '0);
    assign last     = (state_q == IDLE) || (rem_q == WIDTH'(1));

    assign cmd.cmd_ready = !full;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        en_d    = en_q;
        dn_d    = dn_q;
        load_d  = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
            en_d    = 1'b0;
            dn_d    = 1'b0;
        end else if (last) begin
            if (!empty) begin
                pop     = 1'b1;
                state_d = EXEC;
                rem_d   = (head_op == OP_LOAD || zero_len) ? WIDTH'(1) : head_arg;
                en_d    = (head_op == OP_UP || head_op == OP_DOWN) && !zero_len;
                dn_d    = (head_op == OP_DOWN) && !zero_len;
                load_d  = (head_op == OP_LOAD);
                if (head_op == OP_LOAD) data_d = head_arg;
                done_d  = (rem_d == WIDTH'(1));
            end else begin
                state_d = IDLE;
                rem_d   = '0;
                en_d    = 1'b0;
                dn_d    = 1'b0;
            end
        end else begin
            rem_d  = rem_q - WIDTH'(1);
            done_d = (rem_q == WIDTH'(2));
        end
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + (AW+1)'(pop);
        busy_d   = (state_d == EXEC) || (wr_ptr_d != rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q[AW-1:0]]  <= cmd.cmd_op;
            arg_mem_q[wr_ptr_q[AW-1:0]] <= cmd.cmd_arg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            en_q     <= 1'b0;
            dn_q     <= 1'b0;
            load_q   <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            en_q     <= en_d;
            dn_q     <= dn_d;
            load_q   <= load_d;
            data_q   <= data_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign en_o   = en_q;
    assign dn_o   = dn_q;
    assign load_o = load_q;
    assign data_o = data_q;
    assign done_o = done_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Randomized bench for counter_cmd_seq: each accepted command is expanded into its per-cycle
// output records, and the records are replayed one per clock against the DUT outputs.
module tb_counter_cmd_seq;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam logic [1:0] OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_WAIT = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic             en, dn, load, done, busy;
    logic [WIDTH-1:0] data;

    counter_cmd_seq_if #(.WIDTH(WIDTH)) cmd_if ();

    counter_cmd_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd    (cmd_if.slave),
`ifdef CMD_SEQ_FLUSH_EN
        .flush_i(flush),
`endif
        .en_o   (en),
        .dn_o   (dn),
        .load_o (load),
        .data_o (data),
        .busy_o (busy),
        .done_o (done)
    );

    typedef struct packed {
        logic             act;
        logic             first;
        logic             en;
        logic             dn;
        logic             load;
        logic [WIDTH-1:0] data;
        logic             done;
    } rec_t;

    rec_t             exp_q[$];
    rec_t             cur;
    logic [WIDTH-1:0] data_exp;
    logic             ready_exp;
    logic             busy_exp;
    logic             last_acc;
    int               n_chk = 0;
    int               n_fail = 0;
    int               en_cnt, done_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pending_cmds();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].first) n++;
        return n;
    endfunction

    function automatic void expand(input logic [1:0] op, input logic [WIDTH-1:0] arg);
        rec_t r;
        r = '0;
        r.act = 1'b1;
        r.first = 1'b1;
        if (op == OP_LOAD) begin
            r.load = 1'b1;
            r.data = arg;
            r.done = 1'b1;
            exp_q.push_back(r);
        end else if (arg == 0) begin
            r.done = 1'b1;
            exp_q.push_back(r);
        end else begin
            for (int i = 0; i < int'(arg); i++) begin
                r = '0;
                r.act   = 1'b1;
                r.first = (i == 0);
                r.en    = (op != OP_WAIT);
                r.dn    = (op == OP_DOWN);
                r.done  = (i == int'(arg) - 1);
                exp_q.push_back(r);
            end
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        cur       = '0;
        data_exp  = '0;
        ready_exp = 1'b1;
        busy_exp  = 1'b0;
        last_acc  = 1'b0;
    endfunction

    function automatic void model_edge();
        last_acc = cmd_if.cmd_valid && ready_exp && !flush;
        if (flush) begin
            exp_q.delete();
            cur = '0;
        end else begin
            cur = (exp_q.size() != 0) ? exp_q.pop_front() : rec_t'('0);
            if (cur.load) data_exp = cur.data;
            if (last_acc) expand(cmd_if.cmd_op, cmd_if.cmd_arg);
        end
        ready_exp = (pending_cmds() < DEPTH);
        busy_exp  = cur.act || (exp_q.size() != 0);
    endfunction

    task automatic check_outputs();
        chk("en", 32'(en), 32'(cur.en));
        chk("dn", 32'(dn), 32'(cur.dn));
        chk("load", 32'(load), 32'(cur.load));
        chk("done", 32'(done), 32'(cur.done));
        chk("data", 32'(data), 32'(data_exp));
        chk("busy", 32'(busy), 32'(busy_exp));
        chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(ready_exp));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (en) en_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic idle_wait(input int n);
        cmd_if.cmd_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [WIDTH-1:0] arg);
        int c = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_arg   = arg;
        do begin
            step();
            c++;
        end while (!last_acc && c < 100);
        if (!last_acc) chk("push_timeout", 32'd0, 32'd1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_arg   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // LOAD 7: single load cycle, data holds afterwards
        en_cnt = 0; done_cnt = 0;
        push_cmd(OP_LOAD, 4'd7);
        idle_wait(4);
        chk("load7_data_hold", 32'(data), 32'd7);
        chk("load7_done_cnt", 32'(done_cnt), 32'd1);

        // UP 3 then DOWN 2 back-to-back
        en_cnt = 0; done_cnt = 0;
        push_cmd(OP_UP, 4'd3);
        push_cmd(OP_DOWN, 4'd2);
        idle_wait(8);
        chk("updown_en_cnt", 32'(en_cnt), 32'd5);
        chk("updown_done_cnt", 32'(done_cnt), 32'd2);

        // WAIT 15 executing, FIFO filled, one more push stalls until space frees
        done_cnt = 0;
        push_cmd(OP_WAIT, 4'd15);
        idle_wait(1);
        for (int i = 0; i < 4; i++) push_cmd(OP_WAIT, 4'd1);
        chk("full_ready", 32'(cmd_if.cmd_ready), 32'd0);
        push_cmd(OP_WAIT, 4'd1);
        idle_wait(10);
        chk("wait_done_cnt", 32'(done_cnt), 32'd6);
        chk("wait_idle_busy", 32'(busy), 32'd0);

        // UP 0: one empty cycle with done
        en_cnt = 0; done_cnt = 0;
        push_cmd(OP_UP, 4'd0);
        idle_wait(3);
        chk("up0_en_cnt", 32'(en_cnt), 32'd0);
        chk("up0_done_cnt", 32'(done_cnt), 32'd1);

        // Reset in the second cycle of DOWN 5
        push_cmd(OP_DOWN, 4'd5);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        en_cnt = 0; done_cnt = 0;
        push_cmd(OP_UP, 4'd1);
        idle_wait(3);
        chk("post_reset_en_cnt", 32'(en_cnt), 32'd1);

`ifdef CMD_SEQ_FLUSH_EN
        // Flush in the 4th cycle of UP 10 with two commands queued
        done_cnt = 0;
        push_cmd(OP_UP, 4'd10);
        push_cmd(OP_WAIT, 4'd3);
        push_cmd(OP_UP, 4'd2);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_en", 32'(en), 32'd0);
        idle_wait(15);
        chk("flush_done_cnt", 32'(done_cnt), 32'd0);
`endif

        // Randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            cmd_if.cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_if.cmd_op    = 2'($urandom_range(0, 3));
            cmd_if.cmd_arg   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15))
                                                           : WIDTH'($urandom_range(0, 3));
`ifdef CMD_SEQ_FLUSH_EN
            flush = ($urandom_range(0, 59) == 0);
`endif
            step();
        end
        flush = 1'b0;
        idle_wait(80);
        chk("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
